mac_arbiter: RTL and testbench

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_arbiter_if.sv | 33 +++
 rtl/mac_arbiter_rr_arb2.sv | 23 ++
 rtl/mac_arbiter.sv | 141 ++++++++++++++
 tb/tb_mac_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared widths, job limits and FSM encoding for the two-requester MAC arbiter.
package mac_pkg;
  localparam int W_IN    = 4;
  localparam int W_OUT   = 11;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } mac_state_e;
endpackage

// File: rtl/mac_arbiter_if.sv
// Requester job/stream/result signals and the MAC-side operand bus.
interface mac_arbiter_if #(
  parameter int W_IN  = mac_pkg::W_IN,
  parameter int W_OUT = mac_pkg::W_OUT
) ();
  // Handshake: a pair moves when rn_valid && rn_ready are both high at a rising
  // clk edge; rn_valid may rise freely, rn_ready is only ever high while granted.
  logic             r0_req,    r1_req;
  logic [2:0]       r0_len,    r1_len;
  logic [W_IN-1:0]  r0_a,      r1_a;
  logic [W_IN-1:0]  r0_b,      r1_b;
  logic             r0_valid,  r1_valid;
  logic             r0_ready,  r1_ready;
  logic             r0_done,   r1_done;
  logic [W_OUT-1:0] r0_result, r1_result;
  logic [W_IN-1:0]  mac_a, mac_b;
  logic             mac_valid_a, mac_valid_b, mac_clr;
  logic [W_OUT-1:0] mac_out;

  modport slave (
    input  r0_req, r1_req, r0_len, r1_len, r0_a, r1_a, r0_b, r1_b, r0_valid, r1_valid,
    output r0_ready, r1_ready, r0_done, r1_done, r0_result, r1_result,
    output mac_a, mac_b, mac_valid_a, mac_valid_b, mac_clr,
    input  mac_out
  );

  modport master (
    output r0_req, r1_req, r0_len, r1_len, r0_a, r1_a, r0_b, r1_b, r0_valid, r1_valid,
    input  r0_ready, r1_ready, r0_done, r1_done, r0_result, r1_result,
    input  mac_a, mac_b, mac_valid_a, mac_valid_b, mac_clr,
    output mac_out
  );
endinterface

// File: rtl/mac_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances only when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);
  logic last_q, last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    if (take && (|req)) last_d = gnt[1];
  end

  // last_q = 1 after reset so a simultaneous request favours r0.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/mac_arbiter.sv
// Arbitrates two dot-product jobs onto one external MAC: clear, feed beats, drain, report.
module mac_arbiter #(
  parameter int W_IN    = mac_pkg::W_IN,
  parameter int W_OUT   = mac_pkg::W_OUT,
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mac_arbiter_if.slave        bus,
  output mac_pkg::mac_state_e state_o
);
  import mac_pkg::*;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       len_q, len_d;
  logic             gidx_q, gidx_d;
  logic [W_IN-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic             mac_vld_q, mac_vld_d;
  logic [1:0]       done_q, done_d;
  logic [W_OUT-1:0] res0_q, res0_d, res1_q, res1_d;

  logic [1:0]       gnt;
  logic             arb_take, feed, sel_valid, accept;
  logic [W_IN-1:0]  sel_a, sel_b;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.r1_req, bus.r0_req}),
    .take  (arb_take),
    .gnt   (gnt)
  );

  // Only the granted requester's stream is ever looked at.
  assign sel_valid = gidx_q ? bus.r1_valid : bus.r0_valid;
  assign sel_a     = gidx_q ? bus.r1_a     : bus.r0_a;
  assign sel_b     = gidx_q ? bus.r1_b     : bus.r0_b;
  assign feed      = (state_q == S_FEED);
  assign accept    = feed && sel_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gidx_d    = gidx_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_vld_d = 1'b0;
    done_d    = 2'b00;
    res0_d    = res0_q;
    res1_d    = res1_q;
    arb_take  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          arb_take = 1'b1;
          gidx_d   = gnt[1];
          len_d    = gnt[1] ? bus.r1_len : bus.r0_len;
          cnt_d    = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (accept) begin
          mac_a_d   = sel_a;
          mac_b_d   = sel_b;
          mac_vld_d = 1'b1;
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DRAIN: begin
        // MAC_LAT+1 cycles: the final beat lands in the MAC during the first one.
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        done_d[gidx_q] = 1'b1;
        if (gidx_q) res1_d = bus.mac_out;
        else        res0_d = bus.mac_out;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      gidx_q    <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_vld_q <= 1'b0;
      done_q    <= 2'b00;
      res0_q    <= '0;
      res1_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      gidx_q    <= gidx_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_vld_q <= mac_vld_d;
      done_q    <= done_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
    end
  end

  assign bus.r0_ready    = feed && !gidx_q;
  assign bus.r1_ready    = feed &&  gidx_q;
  assign bus.r0_done     = done_q[0];
  assign bus.r1_done     = done_q[1];
  assign bus.r0_result   = res0_q;
  assign bus.r1_result   = res1_q;
  assign bus.mac_a       = mac_a_q;
  assign bus.mac_b       = mac_b_q;
  assign bus.mac_valid_a = mac_vld_q;
  assign bus.mac_valid_b = mac_vld_q;
  assign bus.mac_clr     = (state_q == S_CLEAR);
  assign state_o         = state_q;
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter with a latency-1 accumulator model on the MAC side.
module tb_mac_arbiter;
  import mac_pkg::*;

  logic       clk;
  logic       reset;
  mac_state_e dbg_state;
  logic [10:0] acc;
  logic [7:0]  prod;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_item;
  int n_cmp, n_err;
  int clr_cnt, done0_cnt, done1_cnt;
  logic tog_en;
  logic [3:0] va[8];
  logic [3:0] vb[8];

  mac_arbiter_if #(.W_IN(4), .W_OUT(11)) bus ();

  mac_arbiter #(.W_IN(4), .W_OUT(11), .MAC_LAT(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: clear on reset or mac_clr, product lands one cycle after valid
  assign prod = {4'b0, bus.mac_a} * {4'b0, bus.mac_b};
  always @(posedge clk) begin
    if (reset || bus.mac_clr) acc <= '0;
    else if (bus.mac_valid_a && bus.mac_valid_b) acc <= acc + {3'b0, prod};
  end
  assign bus.mac_out = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: accepted pairs must reach the MAC next cycle, in order
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.mac_clr) clr_cnt++;
      if (bus.r0_done) done0_cnt++;
      if (bus.r1_done) done1_cnt++;
      if (bus.mac_valid_a || bus.mac_valid_b) begin
        check("mac_valid_ab_equal", {31'b0, bus.mac_valid_b}, {31'b0, bus.mac_valid_a});
        if (exp_q.size() == 0) begin
          check("mac_valid_unexpected", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("mac_ab_data", {24'b0, bus.mac_a, bus.mac_b}, {24'b0, exp_item});
        end
      end
      if (bus.r0_ready && bus.r1_ready) check("both_ready", 32'd1, 32'd0);
      if (tog_en) check("r1_ready_while_r0", {31'b0, bus.r1_ready}, 32'd0);
      if (bus.r0_ready && bus.r0_valid) exp_q.push_back({bus.r0_a, bus.r0_b});
      if (bus.r1_ready && bus.r1_valid) exp_q.push_back({bus.r1_a, bus.r1_b});
    end
  end

  // r1 chatter while r0 owns the MAC
  always begin
    @(posedge clk);
    #1;
    if (tog_en) begin
      bus.r1_valid = ~bus.r1_valid;
      bus.r1_a     = 4'($urandom_range(0, 15));
      bus.r1_b     = 4'($urandom_range(0, 15));
    end
  end

  function automatic logic rdy(input int n);
    return (n != 0) ? bus.r1_ready : bus.r0_ready;
  endfunction

  function automatic logic dn(input int n);
    return (n != 0) ? bus.r1_done : bus.r0_done;
  endfunction

  function automatic logic [10:0] res(input int n);
    return (n != 0) ? bus.r1_result : bus.r0_result;
  endfunction

  task automatic drive(input int n, input logic req, input logic valid,
                       input logic [3:0] a, input logic [3:0] b, input logic [2:0] len);
    if (n != 0) begin
      bus.r1_req = req; bus.r1_valid = valid; bus.r1_a = a; bus.r1_b = b; bus.r1_len = len;
    end else begin
      bus.r0_req = req; bus.r0_valid = valid; bus.r0_a = a; bus.r0_b = b; bus.r0_len = len;
    end
  endtask

  // single job from va/vb; req drops after the first beat, gap idle cycles between beats
  task automatic run_job(input int n, input int len, input int gap, input logic [10:0] exp_res);
    int clr0, dn0, cyc;
    logic [10:0] res_hold;
    clr0     = clr_cnt;
    dn0      = (n != 0) ? done1_cnt : done0_cnt;
    res_hold = res(n);
    for (int i = 0; i <= len; i++) begin
      drive(n, (i == 0), 1'b1, va[i], vb[i], 3'(len));
      cyc = 0;
      @(negedge clk);
      while (!rdy(n) && cyc < 50) begin
        cyc++;
        @(negedge clk);
      end
      if (!rdy(n)) begin
        check("ready_timeout", 32'd0, 32'd1);
        drive(n, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        return;
      end
      @(posedge clk);
      #1;
      drive(n, 1'b0, 1'b0, 4'd0, 4'd0, 3'(len));
      if (i < len) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (g > 0) begin
            check("stall_mac_valid", {30'b0, bus.mac_valid_a, bus.mac_valid_b}, 32'd0);
            check("stall_result_hold", {21'b0, res(n)}, {21'b0, res_hold});
          end
          @(posedge clk);
          #1;
        end
      end
    end
    cyc = 0;
    @(negedge clk);
    while (!dn(n) && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("done_seen", {31'b0, dn(n)}, 32'd1);
    check("job_result", {21'b0, res(n)}, {21'b0, exp_res});
    @(negedge clk);
    check("done_one_cycle", {31'b0, dn(n)}, 32'd0);
    check("clr_pulses", 32'(clr_cnt - clr0), 32'd1);
    check("done_pulses", 32'(((n != 0) ? done1_cnt : done0_cnt) - dn0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // both request in one IDLE cycle, len 0: r0 (3,3)=9, r1 (2,7)=14
  task automatic dual_job(input logic first_r1);
    int t0, t1;
    logic s0, s1;
    t0 = -1; t1 = -1; s0 = 1'b0; s1 = 1'b0;
    drive(0, 1'b1, 1'b1, 4'd3, 4'd3, 3'd0);
    drive(1, 1'b1, 1'b1, 4'd2, 4'd7, 3'd0);
    for (int c = 0; c < 60 && (t0 < 0 || t1 < 0); c++) begin
      @(negedge clk);
      if (bus.r0_ready) s0 = 1'b1;
      if (bus.r1_ready) s1 = 1'b1;
      if (bus.r0_done) begin
        t0 = c;
        check("dual_r0_result", {21'b0, bus.r0_result}, 32'd9);
      end
      if (bus.r1_done) begin
        t1 = c;
        check("dual_r1_result", {21'b0, bus.r1_result}, 32'd14);
      end
      @(posedge clk);
      #1;
      if (s0) drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
      if (s1) drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    end
    check("dual_both_done", {31'b0, (t0 >= 0 && t1 >= 0)}, 32'd1);
    check("dual_r1_first", {31'b0, (t1 < t0)}, {31'b0, first_r1});
    check("dual_spacing", 32'(first_r1 ? t0 - t1 : t1 - t0), 32'd6);
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    check({tag, "_mac_ab"}, {24'b0, bus.mac_a, bus.mac_b}, 32'd0);
    check({tag, "_mac_ctl"}, {29'b0, bus.mac_valid_a, bus.mac_valid_b, bus.mac_clr}, 32'd0);
    check({tag, "_ready_done"}, {28'b0, bus.r0_ready, bus.r1_ready, bus.r0_done, bus.r1_done}, 32'd0);
    check({tag, "_results"}, {10'b0, bus.r0_result, bus.r1_result}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1;
    n_cmp = 0; n_err = 0; clr_cnt = 0; done0_cnt = 0; done1_cnt = 0; tog_en = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // after reset r0 wins the tie
    dual_job(1'b0);

    va[0] = 4'd2; vb[0] = 4'd3; va[1] = 4'd4; vb[1] = 4'd5; va[2] = 4'd1; vb[2] = 4'd1;
    run_job(0, 2, 0, 11'd27);

    // r0 was granted last, so the tie now goes to r1
    dual_job(1'b1);

    for (int i = 0; i < 8; i++) begin va[i] = 4'd15; vb[i] = 4'd15; end
    run_job(1, 7, 0, 11'd1800);

    va[0] = 4'd6; vb[0] = 4'd7; va[1] = 4'd5; vb[1] = 4'd3;
    run_job(0, 1, 4, 11'd57);

    tog_en = 1'b1;
    va[0] = 4'd1; vb[0] = 4'd2; va[1] = 4'd3; vb[1] = 4'd4;
    va[2] = 4'd5; vb[2] = 4'd6; va[3] = 4'd7; vb[3] = 4'd8;
    run_job(0, 3, 0, 11'd100);
    tog_en = 1'b0;
    drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    @(posedge clk);
    #1;

    // abort: reset arrives while the third beat is offered
    d0 = done0_cnt; d1 = done1_cnt;
    drive(0, 1'b1, 1'b1, 4'd9, 4'd9, 3'd3);
    for (int c = 0; c < 20 && !bus.r0_ready; c++) begin
      @(negedge clk);
      if (!bus.r0_ready) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 4'd8, 4'd8, 3'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 4'd7, 4'd7, 3'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    check_all_zero("abort");
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'((done0_cnt - d0) + (done1_cnt - d1)), 32'd0);
    @(posedge clk); #1;

    va[0] = 4'd2; vb[0] = 4'd2; va[1] = 4'd3; vb[1] = 4'd3;
    run_job(0, 1, 0, 11'd13);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
